// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, drives the iREN/ihit handshake and is the
// only writer of IF/ID. A one-entry hold buffer parks a fetched word across decode stalls.
module fetch_unit #(
  parameter int               WIDTH   = 32,
  parameter logic [WIDTH-1:0] PC_INIT = '0
) (
  input  logic             CLK,
  input  logic             nRST,
  output logic             imemREN,
  output logic [WIDTH-1:0] imemaddr,
  input  logic             ihit,
  input  logic [WIDTH-1:0] imemload,
  input  logic             stall,
  input  logic             redirect,
  input  logic [WIDTH-1:0] redirect_pc,
  input  logic             halt,
  output logic             ifid_writeEN,
  output logic             ifid_flush,
  output logic [WIDTH-1:0] ifid_pcplus4,
  output logic [WIDTH-1:0] ifid_instr
);

  typedef enum logic [1:0] {FETCH, HOLD, HALTED} state_t;

  state_t           state, state_n;
  logic [WIDTH-1:0] pc, pc_n, hold_pc4, hold_pc4_n, hold_instr, hold_instr_n;
  logic [WIDTH-1:0] pc4;
  logic             ren, wen, flush;
  logic [WIDTH-1:0] pc4_out, instr_out;

  assign pc4 = pc + WIDTH'(4);

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state      <= FETCH;
      pc         <= PC_INIT;
      hold_pc4   <= '0;
      hold_instr <= '0;
    end else begin
      state      <= state_n;
      pc         <= pc_n;
      hold_pc4   <= hold_pc4_n;
      hold_instr <= hold_instr_n;
    end
  end

  // Priority: halt, then redirect, then the ihit/stall handshake.
  always_comb begin
    state_n      = state;
    pc_n         = pc;
    hold_pc4_n   = hold_pc4;
    hold_instr_n = hold_instr;
    ren          = 1'b0;
    wen          = 1'b0;
    flush        = 1'b0;
    pc4_out      = pc4;
    instr_out    = imemload;
    if (halt) begin
      state_n = HALTED;
    end else begin
      case (state)
        FETCH: begin
          ren = 1'b1;
          if (redirect) begin
            flush        = 1'b1;
            pc_n         = redirect_pc;
            hold_pc4_n   = '0;
            hold_instr_n = '0;
          end else if (ihit) begin
            pc_n = pc4;
            if (stall) begin
              hold_pc4_n   = pc4;
              hold_instr_n = imemload;
              state_n      = HOLD;
            end else begin
              wen = 1'b1;
            end
          end
        end
        HOLD: begin
          pc4_out   = hold_pc4;
          instr_out = hold_instr;
          if (redirect) begin
            flush        = 1'b1;
            pc_n         = redirect_pc;
            hold_pc4_n   = '0;
            hold_instr_n = '0;
            state_n      = FETCH;
          end else if (!stall) begin
            wen     = 1'b1;
            state_n = FETCH;
          end
        end
        default: ;
      endcase
    end
  end

  // Outputs are held quiet while reset is asserted, independent of the inputs.
  always_comb begin
    imemREN      = nRST & ren;
    ifid_writeEN = nRST & wen;
    ifid_flush   = nRST & flush;
    imemaddr     = nRST ? pc        : PC_INIT;
    ifid_pcplus4 = nRST ? pc4_out   : '0;
    ifid_instr   = nRST ? instr_out : '0;
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed vector table, randomized run against a
// transaction-level model, then halt/reset and PC wrap sequences.
module tb_fetch_unit;
  logic        CLK = 1'b0;
  logic        nRST;
  logic        ihit, stall, redirect, halt;
  logic [31:0] imemload, redirect_pc;
  logic        ren, wen, fl, ren2, wen2, fl2;
  logic [31:0] addr, pc4, ins, addr2, pc42, ins2;

  always #5 CLK = ~CLK;

  fetch_unit #(.WIDTH(32), .PC_INIT(32'h0)) dut (
    .CLK(CLK), .nRST(nRST), .imemREN(ren), .imemaddr(addr), .ihit(ihit),
    .imemload(imemload), .stall(stall), .redirect(redirect),
    .redirect_pc(redirect_pc), .halt(halt), .ifid_writeEN(wen),
    .ifid_flush(fl), .ifid_pcplus4(pc4), .ifid_instr(ins));

  fetch_unit #(.WIDTH(32), .PC_INIT(32'hFFFF_FFFC)) dut_wrap (
    .CLK(CLK), .nRST(nRST), .imemREN(ren2), .imemaddr(addr2), .ihit(ihit),
    .imemload(imemload), .stall(stall), .redirect(redirect),
    .redirect_pc(redirect_pc), .halt(halt), .ifid_writeEN(wen2),
    .ifid_flush(fl2), .ifid_pcplus4(pc42), .ifid_instr(ins2));

  typedef struct {
    logic        ihit, stall, redir;
    logic [31:0] load, rpc;
    logic        ren, wen, fl, chkd;
    logic [31:0] addr, pc4, ins;
  } vec_t;

  vec_t tbl[20];
  int   n_cmp = 0, n_err = 0;

  function automatic vec_t mk(logic ih, logic [31:0] ld, logic st, logic rd, logic [31:0] rp,
                              logic er, logic ew, logic ef, logic [31:0] ea,
                              logic cd, logic [31:0] ep, logic [31:0] ei);
    vec_t v;
    v.ihit = ih; v.load = ld; v.stall = st; v.redir = rd; v.rpc = rp;
    v.ren = er; v.wen = ew; v.fl = ef; v.addr = ea; v.chkd = cd; v.pc4 = ep; v.ins = ei;
    return v;
  endfunction

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic drive(logic ih, logic [31:0] ld, logic st, logic rd, logic [31:0] rp, logic hl);
    ihit = ih; imemload = ld; stall = st; redirect = rd; redirect_pc = rp; halt = hl;
  endtask

  task automatic chk_ctl(string tag, logic er, logic ew, logic ef, logic [31:0] ea);
    chk({tag, ".ren"},   32'(ren), 32'(er));
    chk({tag, ".wen"},   32'(wen), 32'(ew));
    chk({tag, ".flush"}, 32'(fl),  32'(ef));
    chk({tag, ".addr"},  addr,     ea);
  endtask

  // Transaction-level reference: PC plus an optional parked {pc+4, word}.
  logic [31:0] m_pc, m_hpc4, m_hins;
  bit          m_held;

  initial begin
    bit          r_ih, r_st, r_rd, e_ren, e_wen;
    logic [31:0] r_ld, r_rp, e_pc4, e_ins, frozen;

    tbl[0]  = mk(1, 32'hA0,   0, 0, 0,      1, 1, 0, 32'h0,   1, 32'h4,   32'hA0);
    tbl[1]  = mk(1, 32'hA1,   0, 0, 0,      1, 1, 0, 32'h4,   1, 32'h8,   32'hA1);
    tbl[2]  = mk(1, 32'hA2,   0, 0, 0,      1, 1, 0, 32'h8,   1, 32'hC,   32'hA2);
    tbl[3]  = mk(1, 32'hA3,   0, 0, 0,      1, 1, 0, 32'hC,   1, 32'h10,  32'hA3);
    tbl[4]  = mk(1, 32'hDEAD, 1, 0, 0,      1, 0, 0, 32'h10,  0, 0,       0);
    tbl[5]  = mk(0, 32'h0,    1, 0, 0,      0, 0, 0, 32'h14,  1, 32'h14,  32'hDEAD);
    tbl[6]  = mk(1, 32'h77,   1, 0, 0,      0, 0, 0, 32'h14,  1, 32'h14,  32'hDEAD);
    tbl[7]  = mk(0, 32'h0,    1, 0, 0,      0, 0, 0, 32'h14,  1, 32'h14,  32'hDEAD);
    tbl[8]  = mk(0, 32'h0,    0, 0, 0,      0, 1, 0, 32'h14,  1, 32'h14,  32'hDEAD);
    tbl[9]  = mk(1, 32'hB0,   1, 1, 32'h400, 1, 0, 1, 32'h14, 0, 0,       0);
    tbl[10] = mk(1, 32'hB1,   0, 0, 0,      1, 1, 0, 32'h400, 1, 32'h404, 32'hB1);
    tbl[11] = mk(0, 32'h0,    0, 1, 32'h20, 1, 0, 1, 32'h404, 0, 0,       0);
    tbl[12] = mk(0, 32'h0,    0, 0, 0,      1, 0, 0, 32'h20,  0, 0,       0);
    tbl[13] = mk(0, 32'h0,    0, 0, 0,      1, 0, 0, 32'h20,  0, 0,       0);
    tbl[14] = mk(0, 32'h0,    0, 0, 0,      1, 0, 0, 32'h20,  0, 0,       0);
    tbl[15] = mk(0, 32'h0,    0, 0, 0,      1, 0, 0, 32'h20,  0, 0,       0);
    tbl[16] = mk(1, 32'hC0,   0, 0, 0,      1, 1, 0, 32'h20,  1, 32'h24,  32'hC0);
    tbl[17] = mk(1, 32'hC1,   1, 0, 0,      1, 0, 0, 32'h24,  0, 0,       0);
    tbl[18] = mk(0, 32'h0,    1, 1, 32'h100, 0, 0, 1, 32'h28, 0, 0,       0);
    tbl[19] = mk(1, 32'hC2,   0, 0, 0,      1, 1, 0, 32'h100, 1, 32'h104, 32'hC2);

    // Reset with busy inputs: outputs must still be forced quiet.
    nRST = 1'b0;
    drive(1, 32'h1234_5678, 0, 1, 32'h40, 0);
    repeat (2) @(negedge CLK);
    #2;
    chk_ctl("rst", 0, 0, 0, 32'h0);
    chk("rst.pc4",   pc4,   32'h0);
    chk("rst.instr", ins,   32'h0);
    chk("rst.wrap_addr", addr2, 32'hFFFF_FFFC);

    @(negedge CLK);
    nRST = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (i != 0) @(negedge CLK);
      drive(tbl[i].ihit, tbl[i].load, tbl[i].stall, tbl[i].redir, tbl[i].rpc, 0);
      #2;
      chk_ctl($sformatf("v%0d", i), tbl[i].ren, tbl[i].wen, tbl[i].fl, tbl[i].addr);
      if (tbl[i].chkd) begin
        chk($sformatf("v%0d.pc4", i),   pc4, tbl[i].pc4);
        chk($sformatf("v%0d.instr", i), ins, tbl[i].ins);
      end
      if (i == 0) begin
        chk("wrap.pc4", pc42, 32'h0);
        chk("wrap.wen", 32'(wen2), 32'h1);
      end
      if (i == 1) chk("wrap.addr", addr2, 32'h0);
    end

    // Randomized run against the model.
    m_pc = 32'h104; m_held = 0; m_hpc4 = 0; m_hins = 0;
    for (int c = 0; c < 400; c++) begin
      @(negedge CLK);
      r_ih = ($urandom_range(0, 3) != 0);
      r_st = ($urandom_range(0, 2) == 0);
      r_rd = ($urandom_range(0, 7) == 0);
      r_ld = $urandom;
      r_rp = $urandom & 32'hFFFF_FFFC;
      drive(r_ih, r_ld, r_st, r_rd, r_rp, 0);
      e_ren = !m_held; e_wen = 0; e_pc4 = 0; e_ins = 0;
      if (!r_rd && m_held && !r_st) begin
        e_wen = 1; e_pc4 = m_hpc4; e_ins = m_hins;
      end else if (!r_rd && !m_held && r_ih && !r_st) begin
        e_wen = 1; e_pc4 = m_pc + 4; e_ins = r_ld;
      end
      #2;
      chk_ctl($sformatf("r%0d", c), e_ren, e_wen, r_rd, m_pc);
      if (e_wen) begin
        chk($sformatf("r%0d.pc4", c),   pc4, e_pc4);
        chk($sformatf("r%0d.instr", c), ins, e_ins);
      end
      if (r_rd) begin
        m_pc = r_rp; m_held = 0;
      end else if (m_held) begin
        if (!r_st) m_held = 0;
      end else if (r_ih) begin
        if (r_st) begin
          m_held = 1; m_hpc4 = m_pc + 4; m_hins = r_ld;
        end
        m_pc = m_pc + 4;
      end
    end

    // Halt wins over a coincident redirect, then stays quiet until reset.
    frozen = m_pc;
    @(negedge CLK);
    drive(1, 32'hF0, 0, 1, 32'h800, 1);
    #2;
    chk_ctl("halt", 0, 0, 0, frozen);
    for (int k = 0; k < 4; k++) begin
      @(negedge CLK);
      drive(1, $urandom, 0, k[0], 32'h900, 0);
      #2;
      chk_ctl($sformatf("halted%0d", k), 0, 0, 0, frozen);
    end
    @(negedge CLK);
    nRST = 1'b0;
    #2;
    chk_ctl("rst2", 0, 0, 0, 32'h0);
    @(negedge CLK);
    nRST = 1'b1;
    drive(1, 32'hE0, 0, 0, 0, 0);
    #2;
    chk_ctl("post_rst", 1, 1, 0, 32'h0);
    chk("post_rst.pc4",   pc4, 32'h4);
    chk("post_rst.instr", ins, 32'hE0);
    @(negedge CLK);
    drive(0, 0, 0, 0, 0, 0);
    #2;
    chk("post_rst.addr", addr, 32'h4);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction-fetch stage and sole writer of the IF/ID pipeline latch.
- Owns the PC and issues reads to instruction memory with the iREN/ihit handshake.
- Presents {pc+4, instruction} plus write-enable and flush controls to IF/ID.
- Absorbs decode stalls with a one-entry hold buffer, and handles branch/jump redirects and halt.

Parameters:
- PC_INIT, 32'h0000_0000, PC value loaded on reset.
- WIDTH, 32, width of the PC, address and instruction.

Ports:
- CLK  in  1  system clock, rising edge.
- nRST  in  1  asynchronous active-low reset.
- imemREN  out  1  instruction-memory read request.
- imemaddr  out  WIDTH  instruction-memory address (current PC).
- ihit  in  1  memory returns valid data this cycle.
- imemload  in  WIDTH  instruction word, valid when ihit=1.
- stall  in  1  hazard unit: IF/ID must not be written this cycle.
- redirect  in  1  taken branch/jump resolved downstream.
- redirect_pc  in  WIDTH  target PC, valid when redirect=1.
- halt  in  1  halt instruction reached a later stage.
- ifid_writeEN  out  1  load IF/ID this cycle.
- ifid_flush  out  1  clear IF/ID this cycle.
- ifid_pcplus4  out  WIDTH  pc+4 value to IF/ID.
- ifid_instr  out  WIDTH  instruction to IF/ID.

Behaviour:
- Clock and reset: single clock CLK; nRST is asynchronous, active-low.
- Reset (nRST low):
  - pc=PC_INIT, state=FETCH, hold buffer cleared (hold_pc4=0, hold_instr=0).
  - Outputs forced: imemREN=0, ifid_writeEN=0, ifid_flush=0, imemaddr=PC_INIT, ifid_pcplus4=0, ifid_instr=0.
  - Reset mid-operation discards any in-flight fetch and the hold buffer.
- States: FETCH, HOLD, HALTED. Registered: pc, state, hold_pc4, hold_instr. All outputs are combinational from these registers and the inputs.
- Event priority each cycle: halt > redirect > ihit/stall handling.
- FETCH:
  - imemREN=1, imemaddr=pc.
  - ihit=1, stall=0: ifid_writeEN=1, ifid_pcplus4=pc+4, ifid_instr=imemload; pc<=pc+4; stay in FETCH. One instruction per cycle on consecutive hits.
  - ihit=1, stall=1: ifid_writeEN=0; hold_pc4<=pc+4, hold_instr<=imemload; pc<=pc+4; go to HOLD.
  - ihit=0: ifid_writeEN=0; pc unchanged; stay in FETCH.
- HOLD:
  - imemREN=0; ifid_pcplus4=hold_pc4, ifid_instr=hold_instr.
  - stall=1: ifid_writeEN=0; stay in HOLD.
  - stall=0: ifid_writeEN=1; go to FETCH. The next fetch starts the following cycle.
- Redirect (state FETCH or HOLD, halt=0):
  - ifid_flush=1, ifid_writeEN=0; pc<=redirect_pc; hold buffer invalidated; go to FETCH.
  - A coincident ihit word is discarded.
  - Redirect overrides stall.
- Halt (any state): go to HALTED. In the halt cycle and afterwards: imemREN=0, ifid_writeEN=0, ifid_flush=0, pc frozen. HALTED is exited only by reset.
- Arithmetic: pc+4 is a WIDTH-bit unsigned add; it wraps at 2^WIDTH (32'hFFFF_FFFC+4 = 0). redirect_pc is used unmodified (no alignment check).
- Invariant: ifid_writeEN and ifid_flush are never both 1 in the same cycle.

Test Plan:
- Reset, then ihit=1 every cycle, stall=0, imemload = 0xA0, 0xA1, 0xA2 -> imemaddr = 0, 4, 8; ifid_writeEN=1 each cycle; ifid_pcplus4 = 4, 8, 12 with the matching words.
- ihit=1 at pc=0x10 with stall=1 for 3 cycles, imemload=0xDEAD -> HOLD, imemREN=0, writeEN=0 for 3 cycles; first cycle with stall=0 gives writeEN=1, pcplus4=0x14, instr=0xDEAD; next cycle imemaddr=0x14.
- redirect=1, redirect_pc=0x400, coincident with ihit=1 and stall=1 -> ifid_flush=1, writeEN=0, word dropped; next cycle imemaddr=0x400, imemREN=1.
- ihit held low for 4 cycles at pc=0x20 -> imemaddr stays 0x20, writeEN=0; on ihit=1, pc advances to 0x24.
- halt=1 together with redirect=1 -> no flush; imemREN=0 from then on, writeEN=0 forever; nRST pulse restores pc=PC_INIT and fetching.
- PC_INIT=0xFFFF_FFFC, one hit -> ifid_pcplus4=0, next imemaddr=0.
